// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC: programs ICW1..ICW4 and OCW1 after start,
// services INT with the two-pulse 8086 INTA handshake, and arbitrates runtime mask writes.
module pic_host_sequencer #(
  parameter logic [7:0] ICW1            = 8'h13,
  parameter logic [7:0] ICW2            = 8'h20,
  parameter logic [7:0] ICW3            = 8'h00,
  parameter logic [7:0] ICW4            = 8'h01,
  parameter logic [7:0] OCW1_INIT       = 8'h00,
  parameter int         WR_LOW_CYCLES   = 2,
  parameter int         INTA_LOW_CYCLES = 2,
  parameter int         GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  input  logic       int_in,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       mask_wr_req,
  input  logic [7:0] mask_data,
  output logic       mask_wr_ack,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_a0,
  output logic [7:0] pic_d_out,
  output logic       pic_d_oe,
  input  logic [7:0] pic_d_in,
  output logic       pic_inta_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP,
    S_READY, S_ACK1, S_ACK_GAP, S_ACK2, S_ACK_IDLE
  } state_t;

  typedef enum logic [2:0] {
    ST_ICW1, ST_ICW2, ST_ICW3, ST_ICW4, ST_OCW1
  } step_t;

  localparam logic [15:0] WR_LAST   = 16'(WR_LOW_CYCLES - 1);
  localparam logic [15:0] INTA_LAST = 16'(INTA_LOW_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_init_q, in_init_d;
  logic        init_done_q, init_done_d;
  logic        wr_a0_q, wr_a0_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        vec_valid_q, vec_valid_d;
  logic [7:0]  vec_data_q, vec_data_d;
  logic        ack_q, ack_d;
  logic        int_m, int_s;

  // Successor of an init step, skipping ICW3 in single mode and ICW4 when IC4=0.
  function automatic step_t next_step(input step_t s);
    case (s)
      ST_ICW1: next_step = ST_ICW2;
      ST_ICW2: next_step = !ICW1[1] ? ST_ICW3 : (ICW1[0] ? ST_ICW4 : ST_OCW1);
      ST_ICW3: next_step = ICW1[0] ? ST_ICW4 : ST_OCW1;
      default: next_step = ST_OCW1;
    endcase
  endfunction

  function automatic logic [8:0] step_word(input step_t s);
    case (s)
      ST_ICW1: step_word = {1'b0, ICW1};
      ST_ICW2: step_word = {1'b1, ICW2};
      ST_ICW3: step_word = {1'b1, ICW3};
      ST_ICW4: step_word = {1'b1, ICW4};
      default: step_word = {1'b1, OCW1_INIT};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_m <= 1'b0;
      int_s <= 1'b0;
    end else begin
      int_m <= int_in;
      int_s <= int_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= ST_ICW1;
      cnt_q       <= '0;
      in_init_q   <= 1'b0;
      init_done_q <= 1'b0;
      wr_a0_q     <= 1'b0;
      wr_data_q   <= '0;
      vec_valid_q <= 1'b0;
      vec_data_q  <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
      wr_a0_q     <= wr_a0_d;
      wr_data_q   <= wr_data_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q;
    wr_a0_d     = wr_a0_q;
    wr_data_d   = wr_data_q;
    vec_data_d  = vec_data_q;
    vec_valid_d = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_init_d              = 1'b1;
          step_d                 = ST_ICW1;
          {wr_a0_d, wr_data_d}   = step_word(ST_ICW1);
          state_d                = S_SETUP;
        end
      end

      S_READY: begin
        if (start) begin
          init_done_d            = 1'b0;
          in_init_d              = 1'b1;
          step_d                 = ST_ICW1;
          {wr_a0_d, wr_data_d}   = step_word(ST_ICW1);
          state_d                = S_SETUP;
        end else if (int_s) begin
          cnt_d   = INTA_LAST;
          state_d = S_ACK1;
        // The request is still high in the ack cycle; ignore it there to avoid a duplicate write.
        end else if (mask_wr_req && !ack_q) begin
          in_init_d = 1'b0;
          wr_a0_d   = 1'b1;
          wr_data_d = mask_data;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        cnt_d   = WR_LAST;
        state_d = S_STROBE;
      end

      S_STROBE: begin
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - 16'd1;
      end

      S_HOLD: begin
        cnt_d   = GAP_LAST;
        state_d = S_GAP;
      end

      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (in_init_q) begin
          if (step_q == ST_OCW1) begin
            in_init_d   = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_READY;
          end else begin
            step_d               = next_step(step_q);
            {wr_a0_d, wr_data_d} = step_word(next_step(step_q));
            state_d              = S_SETUP;
          end
        end else begin
          ack_d   = 1'b1;
          state_d = S_READY;
        end
      end

      S_ACK1: begin
        if (cnt_q == '0) state_d = S_ACK_GAP;
        else             cnt_d   = cnt_q - 16'd1;
      end

      S_ACK_GAP: begin
        cnt_d   = INTA_LAST;
        state_d = S_ACK2;
      end

      S_ACK2: begin
        if (cnt_q == '0) begin
          vec_data_d  = pic_d_in;
          vec_valid_d = 1'b1;
          cnt_d       = GAP_LAST;
          state_d     = S_ACK_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_ACK_IDLE: begin
        if (cnt_q == '0) state_d = S_READY;
        else             cnt_d   = cnt_q - 16'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so reset releases them immediately.
  assign pic_cs_n    = !(state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD);
  assign pic_d_oe    =  (state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD);
  assign pic_wr_n    = !(state_q == S_STROBE);
  assign pic_inta_n  = !(state_q == S_ACK1 || state_q == S_ACK2);
  assign pic_rd_n    = 1'b1;
  assign pic_a0      = wr_a0_q;
  assign pic_d_out   = wr_data_q;
  assign busy        = in_init_q && (state_q == S_SETUP || state_q == S_STROBE ||
                                     state_q == S_HOLD  || state_q == S_GAP);
  assign init_done   = init_done_q;
  assign vec_valid   = vec_valid_q;
  assign vec_data    = vec_data_q;
  assign mask_wr_ack = ack_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Bench for pic_host_sequencer: randomized stimulus checked against a bus-level model
// of the init byte list, write timing and INTA handshake.
module tb_pic_host_sequencer;

  localparam int WRL   = 2;
  localparam int INTL  = 2;
  localparam int GAP   = 1;
  localparam int PER_W = WRL + 2 + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       int_in = 1'b0;
  logic       mask_wr_req = 1'b0;
  logic [7:0] mask_data = '0;
  logic [7:0] pic_d_in = '0;

  logic       busy, init_done, vec_valid, mask_wr_ack;
  logic [7:0] vec_data, pic_d_out;
  logic       pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe, pic_inta_n;

  logic       busy2, init_done2, vec_valid2, mask_wr_ack2;
  logic [7:0] vec_data2, pic_d_out2;
  logic       pic_cs_n2, pic_wr_n2, pic_rd_n2, pic_a02, pic_d_oe2, pic_inta_n2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pic_host_sequencer #(
    .WR_LOW_CYCLES(WRL), .INTA_LOW_CYCLES(INTL), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .init_done(init_done),
    .int_in(int_in), .vec_valid(vec_valid), .vec_data(vec_data),
    .mask_wr_req(mask_wr_req), .mask_data(mask_data), .mask_wr_ack(mask_wr_ack),
    .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n), .pic_rd_n(pic_rd_n), .pic_a0(pic_a0),
    .pic_d_out(pic_d_out), .pic_d_oe(pic_d_oe), .pic_d_in(pic_d_in), .pic_inta_n(pic_inta_n)
  );

  pic_host_sequencer #(.ICW1(8'h10)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .init_done(init_done2),
    .int_in(1'b0), .vec_valid(vec_valid2), .vec_data(vec_data2),
    .mask_wr_req(1'b0), .mask_data(8'h00), .mask_wr_ack(mask_wr_ack2),
    .pic_cs_n(pic_cs_n2), .pic_wr_n(pic_wr_n2), .pic_rd_n(pic_rd_n2), .pic_a0(pic_a02),
    .pic_d_out(pic_d_out2), .pic_d_oe(pic_d_oe2), .pic_d_in(8'h00), .pic_inta_n(pic_inta_n2)
  );

  // Bus monitor: records every write {A0,data} and tallies protocol violations.
  logic [8:0] wq[$];
  logic [8:0] wq2[$];
  int setup_bad = 0, hold_bad = 0, len_bad = 0, overlap_bad = 0, rd_bad = 0;
  logic p_wr = 1'b1, p_cs = 1'b1, p_oe = 1'b0, p_wr2 = 1'b1;
  logic [8:0] p_word = '0;
  int run = 0;

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (!pic_wr_n && !pic_inta_n) overlap_bad++;
      if (pic_rd_n !== 1'b1) rd_bad++;
      if (!pic_wr_n) begin
        if (p_wr) begin
          wq.push_back({pic_a0, pic_d_out});
          if (!(p_cs == 1'b0 && p_oe == 1'b1 && p_word == {pic_a0, pic_d_out})) setup_bad++;
        end
        if (pic_cs_n || !pic_d_oe) setup_bad++;
        run++;
      end else if (!p_wr) begin
        if (run != WRL) len_bad++;
        if (pic_cs_n || !pic_d_oe || p_word != {pic_a0, pic_d_out}) hold_bad++;
        run = 0;
      end
    end
    p_wr   = pic_wr_n;
    p_cs   = pic_cs_n;
    p_oe   = pic_d_oe;
    p_word = {pic_a0, pic_d_out};
  end

  always @(negedge clk) begin
    if (!rst && !pic_wr_n2 && p_wr2) wq2.push_back({pic_a02, pic_d_out2});
    p_wr2 = pic_wr_n2;
  end

  // Reference model of the init write list.
  logic [8:0] exp_w [8];
  int exp_n;

  task automatic build_init(input logic [7:0] icw1);
    exp_n = 0;
    exp_w[exp_n++] = {1'b0, icw1};
    exp_w[exp_n++] = {1'b1, 8'h20};
    if (!icw1[1]) exp_w[exp_n++] = {1'b1, 8'h00};
    if (icw1[0])  exp_w[exp_n++] = {1'b1, 8'h01};
    exp_w[exp_n++] = {1'b1, 8'h00};
  endtask

  task automatic do_init(input int extra_at, output int busy_n, output bit done);
    busy_n = 0;
    done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_n++;
      if (init_done) begin done = 1'b1; break; end
      start = (i == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit saw_inta;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n} !== 4'b1111) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 1111", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n});
    end
    checks++;
    if ({pic_a0, pic_d_out, pic_d_oe} !== 10'd0) begin
      failures++;
      $display("FAIL reset_bus: got a0=%b d=%h oe=%b required 0", pic_a0, pic_d_out, pic_d_oe);
    end
    checks++;
    if ({busy, init_done, vec_valid, vec_data, mask_wr_ack} !== 12'd0) begin
      failures++;
      $display("FAIL reset_status: got %h required 0", {busy, init_done, vec_valid, vec_data, mask_wr_ack});
    end
    rst = 1'b0;
    int_in = 1'b1;
    saw_inta = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!pic_inta_n || !pic_cs_n) saw_inta = 1'b1;
    end
    int_in = 1'b0;
    checks++;
    if (saw_inta || busy || init_done) begin
      failures++;
      $display("FAIL idle_ignores_int: got bus_active=%b busy=%b init_done=%b required 0", saw_inta, busy, init_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_init();
    int bn, bad;
    bit done;
    build_init(8'h13);
    wq.delete();
    do_init(-1, bn, done);
    checks++;
    if (!done) begin failures++; $display("FAIL init_timeout: init_done=%b required 1", init_done); end
    checks++;
    if (bn != exp_n * PER_W) begin
      failures++;
      $display("FAIL init_busy_cycles: got %0d required %0d", bn, exp_n * PER_W);
    end
    bad = 0;
    if (wq.size() != exp_n) bad++;
    else for (int i = 0; i < exp_n; i++) if (wq[i] !== exp_w[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_writes: got %0d writes (%0d wrong) required %0d", wq.size(), bad, exp_n);
    end
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_ready: got busy=%b init_done=%b required busy=0 init_done=1", busy, init_done);
    end
  endtask

  task automatic test_cascade();
    int bn, bad;
    bit done;
    build_init(8'h10);
    wq2.delete();
    bn = 0; done = 1'b0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy2) bn++;
      if (init_done2) begin done = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!done || bn != exp_n * PER_W) begin
      failures++;
      $display("FAIL cascade_busy: got done=%b busy_cycles=%0d required 1 and %0d", done, bn, exp_n * PER_W);
    end
    bad = 0;
    if (wq2.size() != exp_n) bad++;
    else for (int i = 0; i < exp_n; i++) if (wq2[i] !== exp_w[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cascade_writes: got %0d writes (%0d wrong) required %0d", wq2.size(), bad, exp_n);
    end
  endtask

  task automatic test_interrupt(input int iters);
    localparam int N = 20;
    for (int it = 0; it < iters; it++) begin
      logic [7:0] d, vd;
      int s, pat_bad, vv_bad, bus_bad, nvv;
      d = 8'($urandom);
      pic_d_in = d;
      vd = '0; pat_bad = 0; vv_bad = 0; bus_bad = 0; nvv = 0;
      s = 3;
      @(negedge clk);
      int_in = 1'b1;
      for (int k = 1; k <= N; k++) begin
        logic e_low, e_vv;
        @(negedge clk);
        e_low = (k >= s && k < s + INTL) || (k >= s + INTL + 1 && k < s + 2 * INTL + 1);
        e_vv  = (k == s + 2 * INTL + 1);
        if (pic_inta_n !== !e_low) pat_bad++;
        if (vec_valid !== e_vv) vv_bad++;
        if (vec_valid) begin vd = vec_data; nvv++; end
        if (!pic_cs_n || pic_d_oe) bus_bad++;
        if (!pic_inta_n) int_in = 1'b0;
      end
      int_in = 1'b0;
      checks++;
      if (pat_bad != 0) begin
        failures++;
        $display("FAIL int_inta_pattern: got %0d wrong cycles required 0", pat_bad);
      end
      checks++;
      if (vv_bad != 0 || nvv != 1) begin
        failures++;
        $display("FAIL int_vec_valid: got %0d pulses, %0d misplaced cycles required 1 pulse", nvv, vv_bad);
      end
      checks++;
      if (vd !== d) begin
        failures++;
        $display("FAIL int_vec_data: got %h required %h", vd, d);
      end
      checks++;
      if (bus_bad != 0) begin
        failures++;
        $display("FAIL int_cs_idle: got %0d cycles with cs/oe active required 0", bus_bad);
      end
    end
  endtask

  task automatic test_mask_write(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [7:0] m;
      int fall_at, ack_at, nack, e_fall, e_ack;
      logic pw;
      m = 8'($urandom);
      wq.delete();
      fall_at = -1; ack_at = -1; nack = 0; pw = 1'b1;
      e_fall = 2;
      e_ack  = e_fall + WRL + 1 + GAP;
      @(negedge clk);
      mask_wr_req = 1'b1;
      mask_data = m;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 1) mask_data = ~m;
        if (!pic_wr_n && pw && fall_at < 0) fall_at = k;
        pw = pic_wr_n;
        if (mask_wr_ack) begin
          nack++;
          if (ack_at < 0) ack_at = k;
          mask_wr_req = 1'b0;
        end
      end
      mask_wr_req = 1'b0;
      checks++;
      if (wq.size() != 1 || wq[0] !== {1'b1, m}) begin
        failures++;
        $display("FAIL mask_write_data: got %0d writes required one of %h", wq.size(), {1'b1, m});
      end
      checks++;
      if (fall_at != e_fall || ack_at != e_ack || nack != 1) begin
        failures++;
        $display("FAIL mask_write_timing: got fall=%0d ack=%0d acks=%0d required %0d %0d 1",
                 fall_at, ack_at, nack, e_fall, e_ack);
      end
    end
  endtask

  task automatic test_mask_vs_int();
    logic [7:0] d, vd;
    int s, vec_at, fall_at, ack_at, nack, pat_bad, e_vec, e_fall, e_ack;
    logic pw;
    d = 8'($urandom);
    pic_d_in = d;
    wq.delete();
    s = 3; vec_at = -1; fall_at = -1; ack_at = -1; nack = 0; pat_bad = 0; vd = '0; pw = 1'b1;
    e_vec  = s + 2 * INTL + 1;
    e_fall = e_vec + GAP + 2;
    e_ack  = e_fall + WRL + 1 + GAP;
    @(negedge clk);
    int_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      logic e_low;
      @(negedge clk);
      e_low = (k >= s && k < s + INTL) || (k >= s + INTL + 1 && k < s + 2 * INTL + 1);
      if (pic_inta_n !== !e_low) pat_bad++;
      if (vec_valid && vec_at < 0) begin vec_at = k; vd = vec_data; end
      if (!pic_wr_n && pw && fall_at < 0) fall_at = k;
      pw = pic_wr_n;
      if (mask_wr_ack) begin
        nack++;
        if (ack_at < 0) ack_at = k;
        mask_wr_req = 1'b0;
      end
      if (k == 2) begin mask_wr_req = 1'b1; mask_data = 8'hF0; end
      if (!pic_inta_n) int_in = 1'b0;
    end
    mask_wr_req = 1'b0;
    int_in = 1'b0;
    checks++;
    if (pat_bad != 0 || vec_at != e_vec || vd !== d) begin
      failures++;
      $display("FAIL arb_ack_first: got bad=%0d vec_at=%0d vec=%h required 0 %0d %h", pat_bad, vec_at, vd, e_vec, d);
    end
    checks++;
    if (wq.size() != 1 || wq[0] !== 9'h1F0) begin
      failures++;
      $display("FAIL arb_mask_write: got %0d writes required one of 1f0", wq.size());
    end
    checks++;
    if (fall_at != e_fall || ack_at != e_ack || nack != 1) begin
      failures++;
      $display("FAIL arb_mask_timing: got fall=%0d ack=%0d acks=%0d required %0d %0d 1",
               fall_at, ack_at, nack, e_fall, e_ack);
    end
  endtask

  task automatic test_start_busy();
    int bn, bad, at;
    bit done;
    build_init(8'h13);
    at = $urandom_range(1, 18);
    wq.delete();
    do_init(at, bn, done);
    checks++;
    if (!done || bn != exp_n * PER_W) begin
      failures++;
      $display("FAIL busy_start_cycles: got done=%b busy=%0d (extra start at %0d) required 1 and %0d",
               done, bn, at, exp_n * PER_W);
    end
    bad = 0;
    if (wq.size() != exp_n) bad++;
    else for (int i = 0; i < exp_n; i++) if (wq[i] !== exp_w[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_start_writes: got %0d writes (%0d wrong) required %0d", wq.size(), bad, exp_n);
    end
  endtask

  task automatic test_reset_mid();
    int nfall, bn, bad;
    bit done;
    logic pw;
    build_init(8'h13);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nfall = 0; pw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!pic_wr_n && pw) nfall++;
      if (nfall == 2) break;
      pw = pic_wr_n;
      @(negedge clk);
    end
    checks++;
    if (nfall != 2 || pic_a0 !== 1'b1 || pic_d_out !== 8'h20) begin
      failures++;
      $display("FAIL rst_reach_icw2: got falls=%0d a0=%b d=%h required 2 1 20", nfall, pic_a0, pic_d_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pic_wr_n, pic_cs_n, pic_d_oe, busy, init_done} !== 5'b11000) begin
      failures++;
      $display("FAIL rst_async: got wr/cs/oe/busy/done=%b required 11000",
               {pic_wr_n, pic_cs_n, pic_d_oe, busy, init_done});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0 || pic_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_stays_idle: got busy=%b init_done=%b cs_n=%b required 0 0 1", busy, init_done, pic_cs_n);
    end
    wq.delete();
    do_init(-1, bn, done);
    bad = 0;
    if (wq.size() != exp_n) bad++;
    else for (int i = 0; i < exp_n; i++) if (wq[i] !== exp_w[i]) bad++;
    checks++;
    if (!done || bn != exp_n * PER_W || bad != 0) begin
      failures++;
      $display("FAIL rst_replay: got done=%b busy=%0d writes=%0d wrong=%0d required 1 %0d %0d 0",
               done, bn, wq.size(), bad, exp_n * PER_W, exp_n);
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (setup_bad != 0 || hold_bad != 0 || len_bad != 0) begin
      failures++;
      $display("FAIL write_phases: got setup=%0d hold=%0d len=%0d violations required 0", setup_bad, hold_bad, len_bad);
    end
    checks++;
    if (overlap_bad != 0 || rd_bad != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: got overlap=%0d rd_low=%0d required 0", overlap_bad, rd_bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_cascade();
    test_interrupt(3);
    test_mask_write(4);
    test_mask_vs_int();
    test_start_busy();
    test_reset_mid();
    test_interrupt(1);
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pic_host_sequencer.md
Name: pic_host_sequencer

Overview:
- Clocked host-side controller that drives the asynchronous 8259-style PIC bus (CS/WR/RD/A0/D/INTA).
- After `start`, issues the programmed ICW1..ICW4 sequence plus an OCW1 mask write.
- Services PIC interrupts by generating the two-pulse 8086 INTA acknowledge and capturing the vector byte.
- Accepts runtime mask (OCW1) updates from a local requester and arbitrates them against interrupt acknowledges.

Parameters:
- ICW1, 8'h13, ICW1 byte. Bit1 SNGL=1 skips ICW3; bit0 IC4=0 skips ICW4.
- ICW2, 8'h20, vector base byte.
- ICW3, 8'h00, cascade byte.
- ICW4, 8'h01, mode byte (8086 mode).
- OCW1_INIT, 8'h00, initial interrupt mask.
- WR_LOW_CYCLES, 2, WR_n low width in clk cycles (>=1).
- INTA_LOW_CYCLES, 2, INTA_n low width per pulse (>=1).
- GAP_CYCLES, 1, bus-idle cycles after every write or acknowledge (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin (re)initialisation
- busy  out  1  init sequence in progress
- init_done  out  1  init complete; PIC serviceable
- int_in  in  1  PIC INT, asynchronous
- vec_valid  out  1  one-cycle pulse; vec_data updated
- vec_data  out  8  captured interrupt vector
- mask_wr_req  in  1  level; request OCW1 write
- mask_data  in  8  OCW1 byte; sampled when request is accepted
- mask_wr_ack  out  1  one-cycle pulse when the mask write completes
- pic_cs_n  out  1  PIC CS, active-low
- pic_wr_n  out  1  PIC WR, active-low
- pic_rd_n  out  1  PIC RD; held 1 (reads unused)
- pic_a0  out  1  PIC A0
- pic_d_out  out  8  PIC data out
- pic_d_oe  out  1  drive pic_d_out onto the bus
- pic_d_in  in  8  PIC data in (vector)
- pic_inta_n  out  1  PIC INTA, active-low

Behaviour:
- Reset (async, immediate, including mid-cycle) forces:
  - all bus strobes high: pic_cs_n=pic_wr_n=pic_rd_n=pic_inta_n=1;
  - pic_a0=0, pic_d_out=0, pic_d_oe=0;
  - busy=0, init_done=0, vec_valid=0, vec_data=0, mask_wr_ack=0;
  - FSM to IDLE.
- int_in passes through a 2-flop synchroniser; int_s lags int_in by 2 cycles.
- Write engine, for one (A0, byte) pair:
  - SETUP, 1 cycle: cs_n=0, wr_n=1, a0 and d_out valid, d_oe=1.
  - STROBE, WR_LOW_CYCLES cycles: wr_n=0.
  - HOLD, 1 cycle: wr_n=1; cs_n, a0, data unchanged.
  - GAP, GAP_CYCLES cycles: cs_n=1, d_oe=0.
  - Total per write: WR_LOW_CYCLES+2+GAP_CYCLES cycles.
- Init sequence:
  - ICW1 (A0=0), then ICW2 (A0=1).
  - ICW3 (A0=1) only if ICW1[1]=0.
  - ICW4 (A0=1) only if ICW1[0]=1.
  - OCW1_INIT (A0=1).
  - busy=1 from the cycle after start through the last GAP cycle. Next cycle: busy=0, init_done=1, FSM to READY.
- start while busy=1 is ignored. start in READY clears init_done and restarts the sequence.
- Interrupts are serviced only when init_done=1. int_s is ignored in IDLE and during init.
- READY arbitration, per cycle:
  - int_s=1 takes priority. mask_wr_req stays pending, with no ack, until READY is re-entered with int_s=0.
  - Otherwise, if mask_wr_req=1: latch mask_data, run the write engine with A0=1. mask_wr_ack pulses in the cycle after its GAP ends.
- Acknowledge:
  - ACK1: inta_n=0 for INTA_LOW_CYCLES.
  - ACK_GAP: inta_n=1 for 1 cycle.
  - ACK2: inta_n=0 for INTA_LOW_CYCLES. pic_d_in is registered into vec_data at the clk edge ending the last ACK2 cycle; inta_n=1 from that edge; vec_valid=1 for exactly that following cycle.
  - Then GAP_CYCLES idle, then READY.
  - pic_cs_n stays 1 and pic_d_oe stays 0 throughout acknowledge.
- int_s dropping during ACK1/ACK2 does not abort. Both pulses always complete; a vector is always reported.
- start during an acknowledge or mask write is accepted once READY is re-entered, only if it is still asserted then.
- At most one of pic_wr_n and pic_inta_n is low in any cycle.

Test Plan:
1. Defaults (SNGL=1, IC4=1), WR_LOW_CYCLES=2, GAP_CYCLES=1, start pulse:
   - bus writes (A0,data) = (0,13h), (1,20h), (1,01h), (1,00h);
   - 5 cycles each; busy high 20 cycles; then init_done=1.
2. ICW1=8'h10 (cascade, no IC4):
   - writes (0,10h), (1,20h), (1,00h), (1,00h); no ICW4 write;
   - ICW3 present, ICW4 absent, all A0 correct.
3. After init, int_in=1, pic_d_in=8'h22:
   - inta_n low 2 cycles, high 1 cycle, low 2 cycles;
   - vec_valid one pulse with vec_data=22h; cs_n stays 1 throughout.
4. Same cycle in READY: mask_wr_req=1 (mask_data=8'hF0) and int_s=1:
   - acknowledge runs first, vector reported;
   - then write (1,F0h); mask_wr_ack pulses once.
5. rst asserted during ICW2 STROBE:
   - same cycle: wr_n=1, cs_n=1, d_oe=0, busy=0, init_done=0;
   - after release, a new start replays the full sequence from ICW1.
6. start asserted while busy=1:
   - ignored; sequence is not restarted or extended; exactly four writes occur.
